// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: the dark segment
// pattern and the active-low hex glyph table, ordered {g,f,e,d,c,b,a}.
package seg7_scan_mux_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Bus between a BCD/hex source and the scanner: digit load side plus the
// board-facing anode/segment pins.
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic                      blank_lz;
    logic [NUM_DIGITS-1:0]     an;
    logic [7:0]                segCode;
    logic                      frame_done;

    modport master (
        output enable, load, digits, dp, blink_mask, blank_lz,
        input  an, segCode, frame_done
    );

    modport slave (
        input  enable, load, digits, dp, blink_mask, blank_lz,
        output an, segCode, frame_done
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Single shared hex-to-segment decoder, fed by the scanner's digit mux.
module seg7_hex_decode
    import seg7_scan_mux_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit multiplexed seven-segment driver with refresh prescaler, frame-aligned
// double-buffered load, leading-zero blanking, decimal points and blink.
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic           clk,
    input  logic           reset,
    seg7_scan_mux_if.slave bus
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_FRAMES) + 1;

    logic [PW-1:0]             r_presc;
    logic [IW-1:0]             r_idx;
    logic [BW-1:0]             r_blinkCnt;
    logic                      r_blinkPhase;

    logic [4*NUM_DIGITS-1:0]   r_pendDigits;
    logic [NUM_DIGITS-1:0]     r_pendDp;
    logic [NUM_DIGITS-1:0]     r_pendBlink;
    logic [4*NUM_DIGITS-1:0]   r_actDigits;
    logic [NUM_DIGITS-1:0]     r_actDp;
    logic [NUM_DIGITS-1:0]     r_actBlink;

    logic [NUM_DIGITS-1:0]     r_an;
    logic [7:0]                r_segCode;
    logic                      r_frameDone;

    logic                      w_tick;
    logic                      w_frameEnd;
    logic [3:0]                w_nibble;
    logic                      w_dpBit;
    logic                      w_blinkBit;
    logic                      w_lzBit;
    logic [NUM_DIGITS-1:0]     w_lzBlank;
    logic                      w_zeroAbove;
    logic                      w_dark;
    logic [6:0]                w_seg;
    logic [NUM_DIGITS-1:0]     w_anLit;

    assign w_tick     = bus.enable && (r_presc == PW'(REFRESH_DIV - 1));
    assign w_frameEnd = w_tick && (r_idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else begin
            if (bus.enable) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
            if (w_tick) begin
                r_idx <= w_frameEnd ? '0 : r_idx + 1'b1;
            end
            if (w_frameEnd) begin
                if (r_blinkCnt == BW'(BLINK_FRAMES - 1)) begin
                    r_blinkCnt   <= '0;
                    r_blinkPhase <= ~r_blinkPhase;
                end else begin
                    r_blinkCnt <= r_blinkCnt + 1'b1;
                end
            end
        end
    end

    // Active contents only change on a frame boundary, so a frame never mixes
    // old and new digits; a load landing on the boundary bypasses straight in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pendDigits <= '0;
            r_pendDp     <= '0;
            r_pendBlink  <= '0;
            r_actDigits  <= '0;
            r_actDp      <= '0;
            r_actBlink   <= '0;
        end else begin
            if (bus.load) begin
                r_pendDigits <= bus.digits;
                r_pendDp     <= bus.dp;
                r_pendBlink  <= bus.blink_mask;
            end
            if (w_frameEnd) begin
                r_actDigits <= bus.load ? bus.digits     : r_pendDigits;
                r_actDp     <= bus.load ? bus.dp         : r_pendDp;
                r_actBlink  <= bus.load ? bus.blink_mask : r_pendBlink;
            end
        end
    end

    always_comb begin
        w_lzBlank   = '0;
        w_zeroAbove = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zeroAbove  = w_zeroAbove && (r_actDigits[4*k +: 4] == 4'h0);
            w_lzBlank[k] = bus.blank_lz && w_zeroAbove;
        end
    end

    always_comb begin
        w_nibble   = '0;
        w_dpBit    = 1'b0;
        w_blinkBit = 1'b0;
        w_lzBit    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_nibble   = r_actDigits[4*k +: 4];
                w_dpBit    = r_actDp[k];
                w_blinkBit = r_actBlink[k];
                w_lzBit    = w_lzBlank[k];
            end
        end
    end

    seg7_hex_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    assign w_anLit = ~(NUM_DIGITS'(1) << r_idx);
    assign w_dark  = !bus.enable || w_lzBit || (r_blinkPhase && w_blinkBit);

    // Pins are registered from the current index, so exactly one anode is low
    // at a time and segments never straddle two digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an        <= '1;
            r_segCode   <= SEG_OFF;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_frameEnd;
            if (w_dark) begin
                r_an      <= '1;
                r_segCode <= SEG_OFF;
            end else begin
                r_an      <= w_anLit;
                r_segCode <= {~w_dpBit, w_seg};
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.segCode    = r_segCode;
    assign bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: directed scenarios plus randomized
// traffic, compared every cycle against a frame-arithmetic reference model.
module tb_seg7_scan_mux;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = RD * ND;

    logic clk;
    logic reset;

    seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_mux #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun;
    int failCount;

    logic [6:0] hexTab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model state: enabled cycles since reset plus the two digit buffers.
    int unsigned modelE;
    logic [15:0] pendDig, actDig;
    logic [3:0]  pendDp, actDp, pendBm, actBm;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: observed=%h expected=%h", tag, $time, observed, expected);
        end
    endtask

    task automatic tick();
        int         idx;
        int         frame;
        bit         phase;
        bit         lz;
        bit         dark;
        bit         boundary;
        logic [3:0] expAn;
        logic [7:0] expSeg;
        logic       expFd;
        logic [3:0] nib;
        boundary = (modelE % FRAME) == FRAME - 1;
        if (reset) begin
            expAn  = 4'hF;
            expSeg = 8'hFF;
            expFd  = 1'b0;
        end else begin
            idx   = (modelE / RD) % ND;
            frame = modelE / FRAME;
            phase = ((frame / BF) % 2) == 1;
            lz    = (idx > 0) && bus.blank_lz && ((actDig >> (4 * idx)) == 16'h0);
            dark  = !bus.enable || lz || (phase && actBm[idx]);
            nib   = actDig[4*idx +: 4];
            if (dark) begin
                expAn  = 4'hF;
                expSeg = 8'hFF;
            end else begin
                expAn  = ~(4'b0001 << idx);
                expSeg = {~actDp[idx], hexTab[nib]};
            end
            expFd = bus.enable && boundary;
        end
        @(posedge clk);
        if (reset) begin
            modelE  = 0;
            pendDig = '0; pendDp = '0; pendBm = '0;
            actDig  = '0; actDp  = '0; actBm  = '0;
        end else begin
            if (bus.enable && boundary) begin
                actDig = bus.load ? bus.digits     : pendDig;
                actDp  = bus.load ? bus.dp         : pendDp;
                actBm  = bus.load ? bus.blink_mask : pendBm;
            end
            if (bus.load) begin
                pendDig = bus.digits;
                pendDp  = bus.dp;
                pendBm  = bus.blink_mask;
            end
            if (bus.enable) modelE++;
        end
        @(negedge clk);
        checkOutput("an", 32'(bus.an), 32'(expAn));
        checkOutput("segCode", 32'(bus.segCode), 32'(expSeg));
        checkOutput("frame_done", 32'(bus.frame_done), 32'(expFd));
    endtask

    task automatic applyStimulus(input bit en, input bit ld, input logic [15:0] dg,
                                 input logic [3:0] dpv, input logic [3:0] bm, input bit blz);
        bus.enable     = en;
        bus.load       = ld;
        bus.digits     = dg;
        bus.dp         = dpv;
        bus.blink_mask = bm;
        bus.blank_lz   = blz;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic runCycles(input int n);
        bus.load = 1'b0;
        repeat (n) tick();
    endtask

    task automatic runToSlot(input int slot);
        int guard;
        guard = 0;
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        while ((modelE % FRAME) != slot && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
    endtask

    task automatic applyReset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        modelE    = 0;
        pendDig = '0; pendDp = '0; pendBm = '0;
        actDig  = '0; actDp  = '0; actBm  = '0;
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.load       = 1'b0;
        bus.digits     = '0;
        bus.dp         = '0;
        bus.blink_mask = '0;
        bus.blank_lz   = 1'b0;
        @(negedge clk);
        applyReset(3);
        checkOutput("reset_an", 32'(bus.an), 32'h0000000F);
        checkOutput("reset_seg", 32'(bus.segCode), 32'h000000FF);

        // Plain digits, then leading-zero blanking cases.
        applyStimulus(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
        runCycles(3 * FRAME);
        applyStimulus(1'b1, 1'b1, 16'h0070, 4'h0, 4'h0, 1'b1);
        runCycles(2 * FRAME + 3);
        applyStimulus(1'b1, 1'b1, 16'h0000, 4'hF, 4'h0, 1'b1);
        runCycles(2 * FRAME);

        // Mid-frame load versus a load on the boundary cycle.
        runToSlot(5);
        applyStimulus(1'b1, 1'b1, 16'hAAAA, 4'h0, 4'h0, 1'b0);
        runCycles(2 * FRAME);
        runToSlot(FRAME - 1);
        applyStimulus(1'b1, 1'b1, 16'h5B3C, 4'h5, 4'h0, 1'b0);
        runCycles(FRAME);

        // Blinking digit with decimal point.
        applyStimulus(1'b1, 1'b1, 16'h0008, 4'h1, 4'h1, 1'b0);
        runCycles(6 * FRAME);

        // Enable dropped mid-digit, a load while dark, then resume.
        runToSlot(6);
        bus.enable = 1'b0;
        runCycles(5);
        applyStimulus(1'b0, 1'b1, 16'hE0F9, 4'h2, 4'h0, 1'b0);
        bus.enable = 1'b1;
        runCycles(2 * FRAME);

        // Reset in the middle of a frame.
        runToSlot(9);
        applyReset(1);
        runCycles(FRAME + 2);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic [15:0] dg;
            for (int k = 0; k < ND; k++)
                dg[4*k +: 4] = (($urandom % 2) == 0) ? 4'h0 : 4'($urandom);
            if (($urandom % 300) == 0) reset = 1'b1;
            applyStimulus(($urandom % 8) != 0, ($urandom % 10) == 0, dg,
                          4'($urandom), 4'($urandom), 1'($urandom));
            reset = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
